// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32M multiply/divide execute unit.
package riscv_pkg;

    // M-extension funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } muldiv_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN       = 32'h80000000;

    // Two's-complement negate when requested (magnitude <-> signed conversion)
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, 32 cycles per start.
// quot/rem present the result of the final step combinationally while done is
// high, so the parent can capture it on the same edge the last step retires.
module div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [31:0] rem_q, quot_q, dvs_q;
    logic [4:0]  cnt;
    logic        run;

    logic [32:0] rem_sh, sub;
    logic        ge;
    logic [31:0] rem_nxt, quot_nxt;

    // One restoring step; rem < divisor keeps the difference inside 33 signed bits
    always_comb begin
        rem_sh   = {rem_q, quot_q[31]};
        sub      = rem_sh - {1'b0, dvs_q};
        ge       = ~sub[32];
        rem_nxt  = ge ? sub[31:0] : rem_sh[31:0];
        quot_nxt = {quot_q[30:0], ge};
    end

    assign done = run && (cnt == 5'd31);
    assign quot = quot_nxt;
    assign rem  = rem_nxt;

    // Load on start, then shift/subtract until the counter wraps past 31
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvs_q  <= divisor;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) run <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: single-issue multiply (2-cycle) and iterative divide,
// result offered to the register-file write port via valid/ready.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_we,
    output logic [4:0]      out_wa,
    output logic [XLEN-1:0] out_wd,
    output logic            busy,
    output logic [4:0]      busy_rd
);

    muldiv_state_e state, state_nxt;
    muldiv_op_e    op_in, op_q;
    logic [31:0]   a_q, b_q;
    logic [4:0]    rd_q;
    logic          neg_q, neg_r;

    logic          accept, is_div, div_zero, div_ovf, special;
    logic          sgn_div, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, spec_res;

    logic          div_done;
    logic [31:0]   div_quot, div_rem, div_res;

    logic [32:0]   a_ext, b_ext;
    logic signed [63:0] a_mul, b_mul, prod;
    logic [31:0]   mul_res;

    assign op_in  = muldiv_op_e'(in_op);
    assign accept = in_valid && in_ready && !flush;

    // Accept-time decode: divide sign handling and the no-iteration special cases
    always_comb begin
        is_div   = in_op[2];
        sgn_div  = (op_in == OP_DIV) || (op_in == OP_REM);
        div_zero = (in_b == 32'd0);
        div_ovf  = sgn_div && (in_a == INT_MIN) && (in_b == 32'hFFFFFFFF);
        special  = is_div && (div_zero || div_ovf);
        a_neg    = sgn_div && in_a[31];
        b_neg    = sgn_div && in_b[31];
        a_mag    = neg_if(a_neg, in_a);
        b_mag    = neg_if(b_neg, in_b);
        if (in_op[1]) spec_res = div_zero ? in_a : 32'd0;          // REM/REMU
        else          spec_res = div_zero ? DIV_BY_ZERO_Q : INT_MIN; // DIV/DIVU
    end

    div_iter u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && is_div && !special),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // Divide fix-up: quotient negated on sign mismatch, remainder follows dividend
    assign div_res = op_q[1] ? neg_if(neg_r, div_rem) : neg_if(neg_q, div_quot);

    // Multiply on 33-bit extended operands; only the low 64 product bits are used,
    // so the extension is carried straight into 64-bit signed operands
    always_comb begin
        a_ext   = {((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[31], a_q};
        b_ext   = {(op_q == OP_MULH) && b_q[31], b_q};
        a_mul   = {{31{a_ext[32]}}, a_ext};
        b_mul   = {{31{b_ext[32]}}, b_ext};
        prod    = a_mul * b_mul;
        mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state; flush wins over every other condition
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = !is_div ? S_MUL : (special ? S_DONE : S_DIV);
            S_MUL:  state_nxt = S_DONE;
            S_DIV:  if (div_done) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // Status and handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
        out_we    = out_valid && (out_wa != 5'd0);
        busy_rd   = busy ? rd_q : 5'd0;
    end

    // Operand latch at accept and result capture into the output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= OP_MUL;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            out_wd <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            a_q   <= in_a;
            b_q   <= in_b;
            rd_q  <= in_rd;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) out_wd <= spec_res;
        end else if (!flush) begin
            if (state == S_MUL)                  out_wd <= mul_res;
            else if (state == S_DIV && div_done) out_wd <= div_res;
        end
    end

    assign out_wa = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expected results.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_we;
    logic [4:0]  out_wa;
    logic [31:0] out_wd;
    logic        busy;
    logic [4:0]  busy_rd;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
        .out_wa(out_wa), .out_wd(out_wd), .busy(busy), .busy_rd(busy_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with out_valid high or after the bound
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    // Issue one op, measure latency in edges from accept, check result and handshake
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int lat,
                          input logic [31:0] exp);
        int cyc;
        in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            chk({tag, "_busyrd"}, 32'(busy_rd), 32'(rd));
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_wd"},  out_wd, exp);
        chk({tag, "_wa"},  32'(out_wa), 32'(rd));
        chk({tag, "_we"},  32'(out_we), 32'(rd != 5'd0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rdy",   32'(in_ready),  32'd1);
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_wd",    out_wd,         32'd0);
        chk("rst_busyrd", 32'(busy_rd),  32'd0);
        reset = 1'b1;

        // Multiplies: 2-edge latency
        run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 2, 32'h00000000);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 2, 32'hFFFFFFFE);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 2, 32'hFFFFFFFF);
        run_op("mul",    3'd0, 32'h12345678, 32'h00000010, 5'd8, 2, 32'h23456780);
        run_op("mul_r0", 3'd0, 32'd3,        32'd5,        5'd0, 2, 32'd15);

        // Iterative divides: 33-edge latency
        run_op("div",   3'd4, 32'hFFFFFFF9, 32'd2,        5'd10, 33, 32'hFFFFFFFD);
        run_op("rem",   3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 33, 32'hFFFFFFFF);
        run_op("divn",  3'd4, 32'd7,        32'hFFFFFFFE, 5'd11, 33, 32'hFFFFFFFD);
        run_op("remn",  3'd6, 32'd7,        32'hFFFFFFFE, 5'd11, 33, 32'd1);
        run_op("divu",  3'd5, 32'd100,      32'd7,        5'd12, 33, 32'd14);
        run_op("remu",  3'd7, 32'd100,      32'd7,        5'd12, 33, 32'd2);

        // Special cases: 1-edge latency
        run_op("divu0", 3'd5, 32'd99,       32'd0,        5'd13, 1, 32'hFFFFFFFF);
        run_op("remu0", 3'd7, 32'h1234,     32'd0,        5'd13, 1, 32'h1234);
        run_op("div0",  3'd4, 32'd5,        32'd0,        5'd14, 1, 32'hFFFFFFFF);
        run_op("divov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1, 32'h80000000);
        run_op("remov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1, 32'd0);

        // Backpressure hold, then no same-cycle re-accept
        in_op = 3'd0; in_a = 32'd6; in_b = 32'd7; in_rd = 5'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("hold");
        repeat (5) begin
            @(negedge clk);
            chk("hold_vld", 32'(out_valid), 32'd1);
            chk("hold_wd",  out_wd,         32'd42);
            chk("hold_rdy", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        in_op = 3'd0; in_a = 32'd2; in_b = 32'd3; in_rd = 5'd7; in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("reacc_idle", 32'(busy),     32'd0);
        chk("reacc_rdy",  32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("reacc_busy", 32'(busy),    32'd1);
        chk("reacc_rd",   32'(busy_rd), 32'd7);
        wait_valid("reacc");
        chk("reacc_wd", out_wd, 32'd6);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush in the middle of a divide
        in_op = 3'd5; in_a = 32'd100; in_b = 32'd3; in_rd = 5'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy),     32'd0);
        chk("flush_rdy",  32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("flush_novld", 32'(seen), 32'd0);

        // Flush together with out_ready in DONE
        in_op = 3'd0; in_a = 32'd1; in_b = 32'd1; in_rd = 5'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("fdone");
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        chk("fdone_vld", 32'(out_valid), 32'd0);
        chk("fdone_we",  32'(out_we),    32'd0);
        chk("fdone_rdy", 32'(in_ready),  32'd1);

        // Asynchronous reset mid-divide
        in_op = 3'd4; in_a = 32'd1000; in_b = 32'd7; in_rd = 5'd21; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_pre", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy",   32'(busy),      32'd0);
        chk("arst_vld",    32'(out_valid), 32'd0);
        chk("arst_rdy",    32'(in_ready),  32'd1);
        chk("arst_wa",     32'(out_wa),    32'd0);
        chk("arst_wd",     out_wd,         32'd0);
        chk("arst_busyrd", 32'(busy_rd),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("post_rst", 3'd0, 32'd9, 32'd9, 5'd2, 2, 32'd81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
